// File: rtl/score_tracker_pkg.sv
// Shared definitions for the score tracker: grade and FSM encodings, timing
// window bases, point values, mod multipliers, level thresholds, and the
// widths of the octave/note/length fields carried with each judged note.
package score_tracker_pkg;

    localparam int OCT_W  = 3;
    localparam int NOTE_W = 4;
    localparam int LEN_W  = 3;

    typedef enum logic [2:0] {
        GRADE_P, GRADE_S, GRADE_A, GRADE_B, GRADE_C, GRADE_MISS
    } grade_e;

    typedef enum logic [2:0] {
        ST_IDLE, ST_JUDGE, ST_WAIT_SCORE, ST_WAIT_ACC, ST_UPDATE
    } state_e;

    // Window bases; all but P shrink by 3*difficulty
    localparam logic [7:0] WIN_P = 8'd16;
    localparam logic [7:0] WIN_S = 8'd64;
    localparam logic [7:0] WIN_A = 8'd97;
    localparam logic [7:0] WIN_B = 8'd127;
    localparam logic [7:0] WIN_C = 8'd188;

    localparam logic [13:0] ACC_FULL  = 14'd10000;
    localparam logic [13:0] LVL_S_MIN = 14'd9500;
    localparam logic [13:0] LVL_A_MIN = 14'd9000;
    localparam logic [13:0] LVL_B_MIN = 14'd8000;
    localparam logic [13:0] LVL_C_MIN = 14'd7000;

    localparam logic [6:0] PCT_DIV = 7'd100;

    // Captured non-timestamp fields of one judged note
    typedef struct packed {
        logic              miss;
        logic [OCT_W-1:0]  hit_oct;
        logic [OCT_W-1:0]  goal_oct;
        logic [NOTE_W-1:0] hit_note;
        logic [NOTE_W-1:0] goal_note;
        logic [LEN_W-1:0]  hit_len;
        logic [LEN_W-1:0]  goal_len;
    } hit_req_t;

    function automatic logic [8:0] grade_points(input grade_e g);
        case (g)
            GRADE_P: return 9'd320;
            GRADE_S: return 9'd300;
            GRADE_A: return 9'd200;
            GRADE_B: return 9'd100;
            GRADE_C: return 9'd50;
            default: return 9'd0;
        endcase
    endfunction

    // Percent multiplier: Normal, NoFail, HalfTime, DoubleTime
    function automatic logic [6:0] mod_mult(input logic [1:0] m);
        case (m)
            2'b00:   return 7'd100;
            2'b01:   return 7'd50;
            2'b10:   return 7'd50;
            default: return 7'd110;
        endcase
    endfunction

    function automatic logic [2:0] acc_level(input logic [13:0] acc, input logic [1:0] m);
        if (acc == ACC_FULL)  return (m == 2'b11) ? 3'd0 : 3'd1;
        if (acc >= LVL_S_MIN) return 3'd2;
        if (acc >= LVL_A_MIN) return 3'd3;
        if (acc >= LVL_B_MIN) return 3'd4;
        if (acc >= LVL_C_MIN) return 3'd5;
        return 3'd6;
    endfunction

endpackage

// File: rtl/score_tracker_seq_divider.sv
// Restoring unsigned divider, one quotient bit per cycle.
// Ports: start (load operands, restarts any division in flight),
// dividend/divisor (W bits), quotient (W bits), done (1-cycle pulse
// W+1 cycles after the start cycle). Divide by zero gives all-ones.
module seq_divider #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] quotient,
    output logic         done
);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, done_q, done_d;
    logic [W:0]    rem_sh;
    logic          ge;

    // Dividend bits shift out of quo_q into the remainder while quotient
    // bits shift in behind them.
    assign rem_sh = {rem_q, quo_q[W-1]};
    assign ge     = rem_sh >= {1'b0, dvs_q};

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = CW'(W);
            run_d = 1'b1;
        end else if (run_q) begin
            // When ge holds the true difference is below 2^W, so W-bit
            // subtraction is exact.
            rem_d = ge ? (rem_sh[W-1:0] - dvs_q) : rem_sh[W-1:0];
            quo_d = {quo_q[W-2:0], ge};
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign quotient = quo_q;
    assign done     = done_q;
endmodule

// File: rtl/score_tracker.sv
// Sequential note scorer. Accepts one judged note per hit_valid/hit_ready
// handshake, grades its timing against difficulty-scaled windows, and keeps
// mod-weighted score, combo/max combo, per-grade counts, accuracy (basis
// points) and letter level. Inputs: start/total_note/mod/difficulty (chart
// setup), hit_* / goal_* (note request). Outputs: score, combo, max_combo,
// cnt_*, acc, level, busy, done, hit_ready.
module score_tracker
    import score_tracker_pkg::*;
#(
    parameter int TIME_W  = 20,
    parameter int SCORE_W = 24,
    parameter int CNT_W   = 16,
    parameter int DIV_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   total_note,
    input  logic [1:0]         mod,
    input  logic [3:0]         difficulty,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  logic               hit_miss,
    input  logic [TIME_W-1:0]  hit_time,
    input  logic [TIME_W-1:0]  goal_time,
    input  logic [OCT_W-1:0]   hit_octave,
    input  logic [OCT_W-1:0]   goal_octave,
    input  logic [NOTE_W-1:0]  hit_note,
    input  logic [NOTE_W-1:0]  goal_note,
    input  logic [LEN_W-1:0]   hit_length,
    input  logic [LEN_W-1:0]   goal_length,
    output logic [SCORE_W-1:0] score,
    output logic [CNT_W-1:0]   combo,
    output logic [CNT_W-1:0]   max_combo,
    output logic [CNT_W-1:0]   cnt_p,
    output logic [CNT_W-1:0]   cnt_s,
    output logic [CNT_W-1:0]   cnt_a,
    output logic [CNT_W-1:0]   cnt_b,
    output logic [CNT_W-1:0]   cnt_c,
    output logic [CNT_W-1:0]   cnt_miss,
    output logic [13:0]        acc,
    output logic [2:0]         level,
    output logic               busy,
    output logic               done
);
    state_e                   state_q, state_d;
    hit_req_t                 req_q, req_d;
    logic [TIME_W-1:0]        ht_q, ht_d, gt_q, gt_d;
    logic [CNT_W-1:0]         total_q, total_d, judged_q, judged_d;
    logic [1:0]               mod_q, mod_d;
    logic [3:0]               diff_q, diff_d;
    logic [SCORE_W-1:0]       score_q, score_d;
    logic [CNT_W-1:0]         combo_q, combo_d, maxc_q, maxc_d;
    logic [5:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [DIV_W-1:0]         raw_q, raw_d;
    logic [13:0]              acc_q, acc_d;
    logic [2:0]               level_q, level_d;
    logic                     done_q, done_d;
    logic                     acc_go_q, acc_go_d;
    logic [DIV_W-1:0]         acc_dvd_q, acc_dvd_d, acc_dvs_q, acc_dvs_d;

    logic                     div_start, div_done;
    logic [DIV_W-1:0]         div_dvd, div_dvs, div_q;

    logic signed [TIME_W:0]   dt;
    logic [TIME_W:0]          t_abs;
    logic [7:0]               d3;
    grade_e                   grade;
    logic [8:0]               pts;
    logic [DIV_W:0]           raw_sum, score_sum;

    function automatic logic [CNT_W-1:0] inc_sat(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Grade of the captured note
    always_comb begin
        dt    = $signed({1'b0, ht_q}) - $signed({1'b0, gt_q});
        t_abs = dt[TIME_W] ? $unsigned(-dt) : $unsigned(dt);
        d3    = {4'b0, diff_q} * 8'd3;
        if (req_q.miss || req_q.hit_oct != req_q.goal_oct ||
            req_q.hit_note != req_q.goal_note || req_q.hit_len != req_q.goal_len)
            grade = GRADE_MISS;
        else if (t_abs < (TIME_W+1)'(WIN_P))      grade = GRADE_P;
        else if (t_abs < (TIME_W+1)'(WIN_S - d3)) grade = GRADE_S;
        else if (t_abs < (TIME_W+1)'(WIN_A - d3)) grade = GRADE_A;
        else if (t_abs < (TIME_W+1)'(WIN_B - d3)) grade = GRADE_B;
        else if (t_abs < (TIME_W+1)'(WIN_C - d3)) grade = GRADE_C;
        else                                      grade = GRADE_MISS;
        pts = grade_points(grade);
    end

    assign raw_sum   = (DIV_W+1)'(raw_q) + (DIV_W+1)'(pts);
    assign score_sum = (DIV_W+1)'(score_q) + (DIV_W+1)'(div_q);

    // The score divide loads straight from the judge logic; the accuracy
    // divide loads from registered operands so the multiplies stay off the
    // divider load path (this costs the one extra cycle in WAIT_ACC).
    assign div_start = (state_q == ST_JUDGE) || acc_go_q;
    assign div_dvd   = (state_q == ST_JUDGE) ? DIV_W'(pts) * DIV_W'(mod_mult(mod_q)) : acc_dvd_q;
    assign div_dvs   = (state_q == ST_JUDGE) ? DIV_W'(PCT_DIV) : acc_dvs_q;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        ht_d      = ht_q;
        gt_d      = gt_q;
        total_d   = total_q;
        judged_d  = judged_q;
        mod_d     = mod_q;
        diff_d    = diff_q;
        score_d   = score_q;
        combo_d   = combo_q;
        maxc_d    = maxc_q;
        cnt_d     = cnt_q;
        raw_d     = raw_q;
        acc_d     = acc_q;
        level_d   = level_q;
        done_d    = done_q;
        acc_go_d  = 1'b0;
        acc_dvd_d = acc_dvd_q;
        acc_dvs_d = acc_dvs_q;
        case (state_q)
            ST_IDLE: begin
                if (total_q == '0) done_d = 1'b1;
                if (hit_valid && hit_ready) begin
                    req_d   = '{hit_miss, hit_octave, goal_octave, hit_note,
                                goal_note, hit_length, goal_length};
                    ht_d    = hit_time;
                    gt_d    = goal_time;
                    state_d = ST_JUDGE;
                end
            end
            ST_JUDGE: begin
                cnt_d[grade] = inc_sat(cnt_q[grade]);
                raw_d        = raw_sum[DIV_W] ? '1 : raw_sum[DIV_W-1:0];
                judged_d     = inc_sat(judged_q);
                case (grade)
                    GRADE_P, GRADE_S: combo_d = inc_sat(combo_q);
                    GRADE_A:          combo_d = combo_q;
                    default:          combo_d = '0;
                endcase
                if (combo_d > maxc_q) maxc_d = combo_d;
                state_d = ST_WAIT_SCORE;
            end
            ST_WAIT_SCORE: begin
                if (div_done) begin
                    score_d = (score_sum > (DIV_W+1)'({SCORE_W{1'b1}})) ? '1 : score_sum[SCORE_W-1:0];
                    // raw*10000/(judged*320) reduced to raw*125/(judged*4):
                    // same quotient, far more headroom before overflow.
                    acc_dvd_d = raw_q * DIV_W'(125);
                    acc_dvs_d = DIV_W'({judged_q, 2'b00});
                    acc_go_d  = 1'b1;
                    state_d   = ST_WAIT_ACC;
                end
            end
            ST_WAIT_ACC: begin
                if (div_done && !acc_go_q) begin
                    acc_d   = (div_q >= DIV_W'(ACC_FULL)) ? ACC_FULL : div_q[13:0];
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                level_d = acc_level(acc_q, mod_q);
                done_d  = (judged_q == total_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d  = ST_IDLE;
            total_d  = total_note;
            mod_d    = mod;
            diff_d   = difficulty;
            judged_d = '0;
            score_d  = '0;
            combo_d  = '0;
            maxc_d   = '0;
            cnt_d    = '0;
            raw_d    = '0;
            acc_d    = ACC_FULL;
            level_d  = 3'd1;
            done_d   = 1'b0;
            acc_go_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            ht_q      <= '0;
            gt_q      <= '0;
            total_q   <= '0;
            judged_q  <= '0;
            mod_q     <= '0;
            diff_q    <= '0;
            score_q   <= '0;
            combo_q   <= '0;
            maxc_q    <= '0;
            cnt_q     <= '0;
            raw_q     <= '0;
            acc_q     <= ACC_FULL;
            level_q   <= 3'd1;
            done_q    <= 1'b0;
            acc_go_q  <= 1'b0;
            acc_dvd_q <= '0;
            acc_dvs_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            ht_q      <= ht_d;
            gt_q      <= gt_d;
            total_q   <= total_d;
            judged_q  <= judged_d;
            mod_q     <= mod_d;
            diff_q    <= diff_d;
            score_q   <= score_d;
            combo_q   <= combo_d;
            maxc_q    <= maxc_d;
            cnt_q     <= cnt_d;
            raw_q     <= raw_d;
            acc_q     <= acc_d;
            level_q   <= level_d;
            done_q    <= done_d;
            acc_go_q  <= acc_go_d;
            acc_dvd_q <= acc_dvd_d;
            acc_dvs_q <= acc_dvs_d;
        end
    end

    // A chart start also clears the divider so a stale division cannot
    // finish into the new chart.
    seq_divider #(.W(DIV_W)) u_div (
        .clk      (clk),
        .rst_n    (rst_n && !start),
        .start    (div_start),
        .dividend (div_dvd),
        .divisor  (div_dvs),
        .quotient (div_q),
        .done     (div_done)
    );

    assign hit_ready = (state_q == ST_IDLE) && !done_q;
    assign busy      = (state_q != ST_IDLE);
    assign score     = score_q;
    assign combo     = combo_q;
    assign max_combo = maxc_q;
    assign cnt_p     = cnt_q[GRADE_P];
    assign cnt_s     = cnt_q[GRADE_S];
    assign cnt_a     = cnt_q[GRADE_A];
    assign cnt_b     = cnt_q[GRADE_B];
    assign cnt_c     = cnt_q[GRADE_C];
    assign cnt_miss  = cnt_q[GRADE_MISS];
    assign acc       = acc_q;
    assign level     = level_q;
    assign done      = done_q;
endmodule
